// File: rtl/ahbl_apb_bridge_mp_if.sv
// Signal bundle for the AHB-Lite to APB bridge: AHB-Lite slave side plus the
// NSLV-way APB master side. The bridge takes the slave modport.
interface ahbl_apb_bridge_mp_if #(
   parameter int NSLV   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                     hsel;
   logic [ADDR_W-1:0]        haddr;
   logic [1:0]               htrans;
   logic                     hwrite;
   logic [2:0]               hsize;
   logic [DATA_W-1:0]        hwdata;
   logic                     hready;
   logic                     hreadyout;
   logic                     hresp;
   logic [DATA_W-1:0]        hrdata;
   logic [ADDR_W-1:0]        paddr;
   logic [NSLV-1:0]          psel;
   logic                     penable;
   logic                     pwrite;
   logic [DATA_W-1:0]        pwdata;
   logic [DATA_W/8-1:0]      pstrb;
   logic [NSLV*DATA_W-1:0]   prdata;
   logic [NSLV-1:0]          pready;
   logic [NSLV-1:0]          pslverr;

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      output hreadyout, hresp, hrdata,
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
      input  hreadyout, hresp, hrdata,
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/ahbl_apb_bridge_mp.sv
// AHB-Lite slave to APB3/APB4 master bridge for NSLV peripherals with window
// decode, wait states, PSLVERR/decode errors mapped to a two-cycle ERROR, and an access timeout.
module ahbl_apb_bridge_mp #(
   parameter int NSLV    = 8,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SLV_AW  = 12,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rstn,
   ahbl_apb_bridge_mp_if.slave bus
);
   localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_ERR1   = 3'd3,
      ST_ERR2   = 3'd4
   } state_t;

   state_t              state_r, state_nx_s;
   logic [IDX_W-1:0]    idx_r, idx_dec_s, idx_nx_s;
   logic [ADDR_W-1:0]   addr_r;
   logic                write_r;
   logic [3:0]          strb_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [DATA_W-1:0]   hrdata_r;
   logic                hreadyout_r, hresp_r, penable_r;
   logic [NSLV-1:0]     psel_r;
   logic                hreadyout_nx_s, hresp_nx_s, penable_nx_s;
   logic [NSLV-1:0]     psel_nx_s, onehot_s;
   logic                accept_s, valid_s, timeout_s;
   logic                sel_ready_s, sel_err_s;
   logic [DATA_W-1:0]   sel_rdata_s;
   logic                unused_s;

   function automatic logic [3:0] calc_strb(input logic [1:0] lo, input logic [2:0] size,
                                            input logic wr);
      logic [3:0] s;
      s = 4'b0000;
      if (wr) begin
         case (size)
            3'd0:    s = 4'b0001 << lo;
            3'd1:    s = 4'b0011 << {lo[1], 1'b0};
            3'd2:    s = 4'b1111;
            default: s = 4'b0000;
         endcase
      end else begin
         s = 4'b0000;
      end
      return s;
   endfunction

   assign unused_s  = bus.htrans[0];
   assign idx_dec_s = bus.haddr[SLV_AW+IDX_W-1:SLV_AW];
   // A new transfer is only taken while the bridge is driving hreadyout high.
   assign accept_s  = bus.hsel & bus.hready & bus.htrans[1] &
                      ((state_r == ST_IDLE) | (state_r == ST_ERR2));
   assign valid_s   = (int'(idx_dec_s) < NSLV) && (bus.hsize <= 3'd2);
   assign timeout_s = (TIMEOUT > 0) && (cnt_r == TO_LAST);
   assign idx_nx_s  = (accept_s & valid_s) ? idx_dec_s : idx_r;

   // Selected-slave response mux; unselected slaves never influence the bridge
   always_comb begin
      sel_ready_s = 1'b0;
      sel_err_s   = 1'b0;
      sel_rdata_s = {DATA_W{1'b0}};
      for (int i = 0; i < NSLV; i++) begin
         sel_ready_s = sel_ready_s | (bus.pready[i] & (idx_r == IDX_W'(i)));
         sel_err_s   = sel_err_s | (bus.pslverr[i] & (idx_r == IDX_W'(i)));
         sel_rdata_s = sel_rdata_s |
                       ({DATA_W{idx_r == IDX_W'(i)}} & bus.prdata[i*DATA_W +: DATA_W]);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE, ST_ERR2: begin
            if (accept_s) begin
               state_nx_s = valid_s ? ST_SETUP : ST_ERR1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETUP: state_nx_s = ST_ACCESS;
         ST_ACCESS: begin
            // pready beats the timeout when both land in the same cycle
            if (sel_ready_s) begin
               state_nx_s = sel_err_s ? ST_ERR1 : ST_IDLE;
            end else if (timeout_s) begin
               state_nx_s = ST_ERR1;
            end else begin
               state_nx_s = ST_ACCESS;
            end
         end
         ST_ERR1: state_nx_s = ST_ERR2;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // One-hot select for the slave the next state will address
   always_comb begin
      onehot_s = {NSLV{1'b0}};
      for (int i = 0; i < NSLV; i++) begin
         onehot_s[i] = (idx_nx_s == IDX_W'(i));
      end
   end

   // Output decode from the next state so the bus outputs come straight from flops
   always_comb begin
      hreadyout_nx_s = 1'b1;
      hresp_nx_s     = 1'b0;
      penable_nx_s   = 1'b0;
      psel_nx_s      = {NSLV{1'b0}};
      case (state_nx_s)
         ST_IDLE: hreadyout_nx_s = 1'b1;
         ST_SETUP: begin
            hreadyout_nx_s = 1'b0;
            psel_nx_s      = onehot_s;
         end
         ST_ACCESS: begin
            hreadyout_nx_s = 1'b0;
            psel_nx_s      = onehot_s;
            penable_nx_s   = 1'b1;
         end
         ST_ERR1: begin
            hreadyout_nx_s = 1'b0;
            hresp_nx_s     = 1'b1;
         end
         ST_ERR2: begin
            hreadyout_nx_s = 1'b1;
            hresp_nx_s     = 1'b1;
         end
         default: hreadyout_nx_s = 1'b1;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hreadyout_r <= 1'b1;
         hresp_r     <= 1'b0;
         penable_r   <= 1'b0;
         psel_r      <= {NSLV{1'b0}};
      end else begin
         hreadyout_r <= hreadyout_nx_s;
         hresp_r     <= hresp_nx_s;
         penable_r   <= penable_nx_s;
         psel_r      <= psel_nx_s;
      end
   end

   // Address-phase capture; rejected transfers leave the APB side untouched
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_r   <= {IDX_W{1'b0}};
         addr_r  <= {ADDR_W{1'b0}};
         write_r <= 1'b0;
         strb_r  <= 4'b0000;
      end else if (accept_s && valid_s) begin
         idx_r   <= idx_dec_s;
         addr_r  <= bus.haddr;
         write_r <= bus.hwrite;
         strb_r  <= calc_strb(bus.haddr[1:0], bus.hsize, bus.hwrite);
      end else begin
         idx_r   <= idx_r;
         addr_r  <= addr_r;
         write_r <= write_r;
         strb_r  <= strb_r;
      end
   end

   // Timeout counter: cleared entering SETUP, advanced while the slave stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_nx_s == ST_SETUP) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_ACCESS) && !sel_ready_s) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Read data capture on a clean read completion only
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hrdata_r <= {DATA_W{1'b0}};
      end else if ((state_r == ST_ACCESS) && sel_ready_s && !sel_err_s && !write_r) begin
         hrdata_r <= sel_rdata_s;
      end else begin
         hrdata_r <= hrdata_r;
      end
   end

   assign bus.hreadyout = hreadyout_r;
   assign bus.hresp     = hresp_r;
   assign bus.hrdata    = hrdata_r;
   assign bus.psel      = psel_r;
   assign bus.penable   = penable_r;
   assign bus.paddr     = addr_r;
   assign bus.pwrite    = write_r;
   assign bus.pstrb     = strb_r;
   assign bus.pwdata    = bus.hwdata;
endmodule

// File: tb/tb_ahbl_apb_bridge_mp.sv
// Self-checking bench for ahbl_apb_bridge_mp: table of AHB transfers against a
// programmable APB slave model, scoreboarded responses, plus reset/BUSY corner sequences.
`timescale 1ns/1ps
module tb_ahbl_apb_bridge_mp;
   localparam int NSLV = 5, ADDR_W = 32, DATA_W = 32, SLV_AW = 12, TIMEOUT = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ahbl_apb_bridge_mp_if #(.NSLV(NSLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ahbl_apb_bridge_mp #(.NSLV(NSLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .SLV_AW(SLV_AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn), .bus(bus)
   );

   assign bus.hready = bus.hreadyout;

   typedef struct {
      int          gap;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          wt;
      logic        perr;
      logic        exp_err;
      int          exp_low;
      int          exp_psel;
      logic [3:0]  exp_strb;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          low;
   } exp_t;

   vec_t        vecs[11];
   exp_t        sb_q[$];
   logic [31:0] slv_rdata[NSLV];
   int          wait_cfg;
   logic        err_cfg;
   int          acc_cnt;
   int          n_applied = 0;
   int          n_miss = 0;

   // APB slave model: the selected slave answers after wait_cfg ACCESS cycles,
   // every unselected slave shouts ready+error so any wrong observation shows up.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) acc_cnt <= 0;
      else if (bus.penable && !(|(bus.psel & bus.pready))) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always_comb begin
      bus.prdata  = '0;
      bus.pready  = '0;
      bus.pslverr = '0;
      for (int i = 0; i < NSLV; i++) begin
         bus.prdata[i*DATA_W +: DATA_W] = slv_rdata[i];
         if (bus.psel[i]) begin
            bus.pready[i]  = bus.penable && (acc_cnt == wait_cfg);
            bus.pslverr[i] = bus.penable && (acc_cnt == wait_cfg) && err_cfg;
         end else begin
            bus.pready[i]  = 1'b1;
            bus.pslverr[i] = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " hreadyout"}, 32'(bus.hreadyout), 32'd1);
      check({tag, " hresp"},     32'(bus.hresp),     32'd0);
      check({tag, " hrdata"},    bus.hrdata,         32'd0);
      check({tag, " psel"},      32'(bus.psel),      32'd0);
      check({tag, " penable"},   32'(bus.penable),   32'd0);
      check({tag, " pwrite"},    32'(bus.pwrite),    32'd0);
      check({tag, " paddr"},     bus.paddr,          32'd0);
      check({tag, " pstrb"},     32'(bus.pstrb),     32'd0);
   endtask

   // Drives one transfer starting at the current negedge and returns at the
   // negedge where hreadyout is seen high (the completion cycle).
   task automatic run_vec(input vec_t v, input int n);
      exp_t            e;
      int              low, pcyc;
      logic            errlow, done;
      logic [2:0]      sidx;
      logic [NSLV-1:0] ohot;
      string           tg;
      tg   = $sformatf("v%0d", n);
      sidx = v.addr[SLV_AW +: 3];
      ohot = '0;
      if (int'(sidx) < NSLV) ohot[sidx] = 1'b1;
      wait_cfg = v.wt;
      err_cfg  = v.perr;
      sb_q.push_back('{v.exp_err, v.exp_rdata, v.exp_low});
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = v.addr;
      bus.hwrite = v.wr; bus.hsize = v.size;
      @(negedge clk);
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = v.wdata;
      low = 0; pcyc = 0; errlow = 1'b0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (bus.hreadyout) begin
            done = 1'b1;
         end else begin
            low++;
            if (bus.hresp) errlow = 1'b1;
            if (bus.psel != '0) begin
               pcyc++;
               check({tg, " psel"},    32'(bus.psel),    32'(ohot));
               check({tg, " penable"}, 32'(bus.penable), (pcyc > 1) ? 32'd1 : 32'd0);
               check({tg, " pstrb"},   32'(bus.pstrb),   32'(v.exp_strb));
               check({tg, " paddr"},   bus.paddr,        v.addr);
               check({tg, " pwrite"},  32'(bus.pwrite),  32'(v.wr));
               if (bus.penable) check({tg, " pwdata"}, bus.pwdata, v.wdata);
            end
            @(negedge clk);
         end
      end
      check({tg, " completed"}, 32'(done), 32'd1);
      e = sb_q.pop_front();
      check({tg, " wait_cycles"}, 32'(low),        32'(e.low));
      check({tg, " psel_cycles"}, 32'(pcyc),       32'(v.exp_psel));
      check({tg, " hresp_end"},   32'(bus.hresp),  32'(e.err));
      check({tg, " hresp_wait"},  32'(errlow),     32'(e.err));
      check({tg, " hrdata"},      bus.hrdata,      e.rdata);
   endtask

   initial begin
      slv_rdata[0] = 32'h1111_0000;
      slv_rdata[1] = 32'h2222_1111;
      slv_rdata[2] = 32'hDEAD_BEEF;
      slv_rdata[3] = 32'h3333_C0DE;
      slv_rdata[4] = 32'h4444_4444;
      //            gap wr    addr          size  wdata         wt  perr  err   low psel strb     rdata
      vecs[0]  = '{1, 1'b0, 32'h0000_2004, 3'd2, 32'h0,        0,  1'b0, 1'b0, 2, 2, 4'b0000, 32'hDEAD_BEEF};
      vecs[1]  = '{1, 1'b1, 32'h0000_1003, 3'd0, 32'hAB00_0000, 3, 1'b0, 1'b0, 5, 5, 4'b1000, 32'hDEAD_BEEF};
      vecs[2]  = '{1, 1'b1, 32'h0000_0010, 3'd2, 32'h1234_5678, 0, 1'b1, 1'b1, 3, 2, 4'b1111, 32'hDEAD_BEEF};
      vecs[3]  = '{1, 1'b0, 32'h0000_6000, 3'd2, 32'h0,        0,  1'b0, 1'b1, 1, 0, 4'b0000, 32'hDEAD_BEEF};
      vecs[4]  = '{1, 1'b0, 32'h0000_4008, 3'd2, 32'h0,        99, 1'b0, 1'b1, 6, 5, 4'b0000, 32'hDEAD_BEEF};
      vecs[5]  = '{1, 1'b0, 32'h0000_4008, 3'd2, 32'h0,        3,  1'b0, 1'b0, 5, 5, 4'b0000, 32'h4444_4444};
      vecs[6]  = '{1, 1'b1, 32'h0000_3002, 3'd1, 32'h5566_0000, 1, 1'b0, 1'b0, 3, 3, 4'b1100, 32'h4444_4444};
      vecs[7]  = '{1, 1'b1, 32'h0000_0001, 3'd0, 32'h0000_CD00, 0, 1'b0, 1'b0, 2, 2, 4'b0010, 32'h4444_4444};
      vecs[8]  = '{1, 1'b0, 32'h0000_1000, 3'd3, 32'h0,        0,  1'b0, 1'b1, 1, 0, 4'b0000, 32'h4444_4444};
      vecs[9]  = '{0, 1'b0, 32'h0000_0000, 3'd2, 32'h0,        0,  1'b0, 1'b0, 2, 2, 4'b0000, 32'h1111_0000};
      vecs[10] = '{0, 1'b0, 32'h0000_3000, 3'd2, 32'h0,        0,  1'b0, 1'b0, 2, 2, 4'b0000, 32'h3333_C0DE};

      wait_cfg = 0; err_cfg = 1'b0;
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'h0;
      bus.hwrite = 1'b0; bus.hsize = 3'd0; bus.hwdata = 32'h0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rstn = 1'b1;
      @(negedge clk);
      check_reset_values("post_reset");

      for (int i = 0; i < 11; i++) begin
         for (int g = 0; g < vecs[i].gap; g++) @(negedge clk);
         run_vec(vecs[i], i);
      end

      // BUSY transfer: zero-wait OKAY and no APB activity
      @(negedge clk);
      bus.hsel = 1'b1; bus.htrans = 2'b01; bus.haddr = 32'h0000_2000;
      @(negedge clk);
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      check("busy hreadyout", 32'(bus.hreadyout), 32'd1);
      check("busy hresp",     32'(bus.hresp),     32'd0);
      check("busy psel",      32'(bus.psel),      32'd0);

      // Back-to-back pair, reset dropped during the second ACCESS
      @(negedge clk);
      run_vec(vecs[9], 90);
      wait_cfg = 99;
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h0000_3004;
      bus.hwrite = 1'b0; bus.hsize = 3'd2;
      @(negedge clk);
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      check("b2b setup psel",    32'(bus.psel),    32'h0000_0008);
      check("b2b setup penable", 32'(bus.penable), 32'd0);
      @(negedge clk);
      check("b2b access psel",    32'(bus.psel),    32'h0000_0008);
      check("b2b access penable", 32'(bus.penable), 32'd1);
      #2 rstn = 1'b0;
      #1 check_reset_values("async_reset");
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("after_reset psel",      32'(bus.psel),      32'd0);
      check("after_reset hreadyout", 32'(bus.hreadyout), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end
endmodule
